// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration and one registered output slot.
// Define STREAM_MUX_LOCK_EN to add in_last/out_last and hold the grant on a channel until its last beat.
module stream_mux_rr #(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [N-1:0]    in_last,
    output logic            out_last,
`endif
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [SW-1:0] ptr_p1;
    logic [W-1:0]  data_p1;
    logic [SW-1:0] ch_p1;
    logic          vld_p1;

    logic          load;
    logic          xfer;
    logic [SW-1:0] grant;
    logic          grant_valid;
    logic [SW-1:0] rr_grant;
    logic          rr_valid;
    logic          fix_valid;
    logic [W-1:0]  grant_data;

`ifdef STREAM_MUX_LOCK_EN
    logic          lock_p1;
    logic [SW-1:0] lock_ch_p1;
    logic          last_p1;
    logic          grant_last;
    logic          lock_valid;
`endif

    assign load = !vld_p1 || out_ready;

    // Round-robin: scan ptr+N down to ptr+1 so the nearest valid channel after ptr is the one kept.
    always_comb begin
        int idx;
        idx      = 0;
        rr_grant = '0;
        rr_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_p1) + k) % N;
            if (in_valid[idx]) begin
                rr_grant = SW'(idx);
                rr_valid = 1'b1;
            end
        end
    end

    // sel values at or above N never match a channel, so they yield no grant.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) fix_valid = in_valid[i];
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_comb begin
        lock_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(lock_ch_p1) == i) lock_valid = in_valid[i];
        end
    end
`endif

    always_comb begin
        grant       = mode ? rr_grant : sel;
        grant_valid = mode ? rr_valid : fix_valid;
`ifdef STREAM_MUX_LOCK_EN
        if (lock_p1) begin
            grant       = lock_ch_p1;
            grant_valid = lock_valid;
        end
`endif
    end

    // Reset suppresses every ready so no producer sees a transfer that the reset discards.
    assign xfer = load && grant_valid && !rst;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
`ifdef STREAM_MUX_LOCK_EN
        grant_last = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (int'(grant) == i) begin
                in_ready[i] = xfer;
                grant_data  = in_data[i*W +: W];
`ifdef STREAM_MUX_LOCK_EN
                grant_last  = in_last[i];
`endif
            end
        end
    end

    // ---- output stage p1 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr_p1  <= SW'(N - 1);
        end else begin
            if (load) begin
                vld_p1 <= grant_valid;
                if (grant_valid) begin
                    data_p1 <= grant_data;
                    ch_p1   <= grant;
                end
            end
            if (xfer && mode) ptr_p1 <= grant;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_p1    <= 1'b0;
            lock_ch_p1 <= '0;
            last_p1    <= 1'b0;
        end else if (xfer) begin
            lock_p1    <= !grant_last;
            lock_ch_p1 <= grant;
            last_p1    <= grant_last;
        end
    end

    assign out_last = last_p1;
`endif

    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (default build): N=8 instance against a behavioural model
// with directed literal checks, plus an N=6 instance for out-of-range select handling.
module tb_stream_mux_rr;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, mode, out_ready, out_valid;
    logic [SW-1:0]   sel, out_ch;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_ready;
    logic [W-1:0]    out_data;

    logic            rst6, mode6, out_ready6, out_valid6;
    logic [2:0]      sel6, out_ch6;
    logic [6*W-1:0]  in_data6;
    logic [5:0]      in_valid6, in_ready6;
    logic [W-1:0]    out_data6;

    int n_cmp = 0;
    int n_bad = 0;

    stream_mux_rr #(.N(N), .W(W)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N(6), .W(W)) u_dut6 (
        .clk(clk), .rst(rst6), .mode(mode6), .sel(sel6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
        .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules pick: fixed -> sel if in range and valid; RR -> first valid after ptr.
    function automatic int pick(input logic m, input int s, input logic [N-1:0] v, input int p);
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    bit           m_init = 0;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    always @(posedge clk) begin
        int g;
        bit ld;
        if (rst) begin
            m_init  = 1;
            m_valid = 0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = N - 1;
        end else if (m_init) begin
            ld = !m_valid || out_ready;
            g  = pick(mode, int'(sel), in_valid, m_ptr);
            if (ld) begin
                if (g >= 0) begin
                    m_valid = 1;
                    m_data  = in_data[g*W +: W];
                    m_ch    = g;
                    if (mode) m_ptr = g;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (m_init) begin
            g = pick(mode, int'(sel), in_valid, m_ptr);
            exp_rdy = '0;
            if (!rst && (!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            chk("model in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("model out_valid", 64'(out_valid), 64'(m_valid));
            chk("model out_data", 64'(out_data), 64'(m_data));
            chk("model out_ch", 64'(out_ch), 64'(m_ch));
        end
    end

    int exp_rr[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 5, 2, 5};
    int exp_nl[3]  = '{1, 2, 0};

    initial begin
        logic [W-1:0] held;
        rst = 1; mode = 1; sel = 0; in_valid = 8'hFF; out_ready = 1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        rst6 = 1; mode6 = 0; sel6 = 0; in_valid6 = 6'h3F; out_ready6 = 1;
        for (int i = 0; i < 6; i++) in_data6[i*W +: W] = W'($urandom);

        // reset with all inputs active
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset out_valid", 64'(out_valid), 0);
            chk("reset out_data", 64'(out_data), 0);
            chk("reset out_ch", 64'(out_ch), 0);
            chk("reset in_ready", 64'(in_ready), 0);
        end

        // fixed select, ch3
        rst = 0; mode = 0; sel = 3; in_data[3*W +: W] = 8'hA5;
        #1 chk("fixed in_ready", 64'(in_ready), 64'h08);
        @(posedge clk); #1;
        chk("fixed out_data", 64'(out_data), 64'hA5);
        chk("fixed out_ch", 64'(out_ch), 3);
        in_data[3*W +: W] = 8'h5A;
        #1 chk("fixed in_ready b2b", 64'(in_ready), 64'h08);
        @(posedge clk); #1;
        chk("fixed out_data b2b", 64'(out_data), 64'h5A);
        chk("fixed out_valid b2b", 64'(out_valid), 1);

        // round-robin from reset
        rst = 1; mode = 1; in_valid = 8'hFF;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 9) ? 8'hFF : 8'h24;
            @(posedge clk); #1;
            chk($sformatf("rr out_ch[%0d]", i), 64'(out_ch), 64'(exp_rr[i]));
        end

        // backpressure: hold ch5 beat, then resume with no gap
        held = out_data;
        out_ready = 0;
        repeat (3) begin
            #1 chk("bp in_ready", 64'(in_ready), 0);
            @(posedge clk); #1;
            chk("bp out_data", 64'(out_data), 64'(held));
            chk("bp out_ch", 64'(out_ch), 5);
            chk("bp out_valid", 64'(out_valid), 1);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp resume out_ch", 64'(out_ch), 2);
        chk("bp resume out_valid", 64'(out_valid), 1);

        // per-beat arbitration without lock: after ch0, channels 0..2 valid -> 1,2,0
        rst = 1; @(posedge clk); #1;
        rst = 0; in_valid = 8'h01;
        @(posedge clk); #1;
        chk("nolock first", 64'(out_ch), 0);
        in_valid = 8'h07;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("nolock out_ch[%0d]", i), 64'(out_ch), 64'(exp_nl[i]));
        end

        // N=6: sel beyond range gives no grant
        rst6 = 0; sel6 = 1;
        @(posedge clk); #1;
        chk("n6 first out_ch", 64'(out_ch6), 1);
        chk("n6 first out_valid", 64'(out_valid6), 1);
        sel6 = 7;
        #1 chk("n6 sel7 in_ready", 64'(in_ready6), 0);
        @(posedge clk); #1;
        chk("n6 sel7 out_valid", 64'(out_valid6), 0);
        out_ready6 = 0;
        @(posedge clk); #1;
        chk("n6 idle out_valid", 64'(out_valid6), 0);
        sel6 = 5; out_ready6 = 1; in_data6[5*W +: W] = 8'hC3;
        #1 chk("n6 sel5 in_ready", 64'(in_ready6), 64'h20);
        @(posedge clk); #1;
        chk("n6 sel5 out_ch", 64'(out_ch6), 5);
        chk("n6 sel5 out_data", 64'(out_data6), 64'hC3);
        chk("n6 sel5 out_valid", 64'(out_valid6), 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = SW'($urandom);
            in_valid  = N'($urandom) & N'($urandom | (c[6] ? 32'h0 : 32'hFFFF_FFFF));
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        end
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
